period_gate_counter: RTL and testbench

Measures the average period of an external signal using equal-precision gating. It counts clk cycles (Ns) and signal rising edges (Nx) over a gate that opens and closes on signal edges. It presents Ns as dividend and Nx as divisor to the downstream pipelined divider (quotient = mean period in clk cycles). Because the divider carries no valid signal, this block also generates the result-valid strobe aligned to the divider's fixed latency.

---
 rtl/period_gate_counter_pkg.sv | 24 ++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/period_gate_counter.sv | 195 +++++++++++++++++++
 tb/tb_period_gate_counter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_gate_counter_pkg.sv
// Shared types and sizing helpers for the equal-precision period counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package period_gate_counter_pkg;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Latency of the downstream pipelined divider: one stage per quotient bit
   function automatic int lat_of(input int m, input int n);
      return m - n;
   endfunction

   // Width needed for the gate timer to represent GATE_CYCLES itself
   function automatic int gate_timer_width(input int gate_cycles);
      return $clog2(gate_cycles + 1);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered rising-edge pulse.
// Latency: 3 clk cycles from sig_in rising to edge_pulse high (one cycle wide).
// Backpressure: none; free-running, every synchronized rising edge produces a pulse.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic edge_pulse
);

   logic meta;
   logic sync;
   logic sync_d;

   // Resolve metastability, keep previous sample, and register the edge pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta       <= 1'b0;
         sync       <= 1'b0;
         sync_d     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         meta       <= sig_in;
         sync       <= meta;
         sync_d     <= sync;
         edge_pulse <= sync & ~sync_d;
      end
   end

endmodule

// File: rtl/period_gate_counter.sv
// Equal-precision period meter: counts clk cycles (Ns) and signal edges (Nx) over an edge-aligned gate, feeds a divider.
// Latency: op_valid one cycle after the closing edge is seen; q_valid exactly LAT cycles after op_valid.
// Backpressure: none; the divider is fully pipelined, operands are held stable until the next result.
module period_gate_counter
   import period_gate_counter_pkg::*;
#(
   parameter int M           = 26,
   parameter int N           = 14,
   parameter int GATE_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         continuous,
   input  logic         sig_in,
   output logic [M-1:0] dividend,
   output logic [N-1:0] divisor,
   output logic         op_valid,
   output logic         q_valid,
   output logic         busy,
   output logic         ovf
);

   // Divider latency is fixed by its operand widths (requires M > N)
   localparam int LAT = lat_of(M, N);
   localparam int TW  = gate_timer_width(GATE_CYCLES);
   localparam int QW  = (LAT > 0) ? $clog2(LAT + 1) : 1;

   // Last Ns value before the counter would hit all-ones, i.e. 2^M-2
   localparam logic [M-1:0]  NS_LAST  = {{(M-1){1'b1}}, 1'b0};
   // Nx value at which the next edge completes 2^N-1 periods
   localparam logic [N-1:0]  NX_LAST  = {{(N-1){1'b1}}, 1'b0};
   localparam logic [TW-1:0] GATE_LEN = TW'(GATE_CYCLES);
   localparam logic [QW-1:0] LAT_LOAD = QW'(LAT);

   state_t          state;
   state_t          state_nxt;
   logic            sig_edge;
   logic [M-1:0]    ns_cnt;
   logic [N-1:0]    nx_cnt;
   logic [TW-1:0]   gate_timer;
   logic [QW-1:0]   q_cnt;
   logic            gate_close;
   logic            ns_timeout;
   logic            err_q;

   sync_edge_detect u_sync_edge_detect (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .edge_pulse (sig_edge)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the gate-close and timeout decisions
   always_comb begin
      state_nxt  = state;
      gate_close = 1'b0;
      ns_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            // An opening edge wins over a timeout in the same cycle
            if (sig_edge) begin
               state_nxt = ST_GATE;
            end else if (ns_cnt == NS_LAST) begin
               ns_timeout = 1'b1;
               state_nxt  = ST_DONE;
            end
         end
         ST_GATE: begin
            gate_close = sig_edge && ((gate_timer >= GATE_LEN) || (nx_cnt == NX_LAST));
            if (gate_close) begin
               state_nxt = ST_DONE;
            end else if (ns_cnt == NS_LAST) begin
               ns_timeout = 1'b1;
               state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = continuous ? ST_ARM : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Ns / Nx / gate timer: cleared between measurements, saturating while running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ns_cnt     <= '0;
         nx_cnt     <= '0;
         gate_timer <= '0;
      end else begin
         case (state)
            ST_ARM: begin
               if (sig_edge) begin
                  // The opening edge starts the first period; it is not itself counted
                  ns_cnt     <= M'(1);
                  nx_cnt     <= '0;
                  gate_timer <= TW'(1);
               end else if (ns_cnt != '1) begin
                  ns_cnt <= ns_cnt + M'(1);
               end
            end
            ST_GATE: begin
               if (gate_close) begin
                  // Closing edge ends the last whole period: count it, but not its cycle
                  nx_cnt <= nx_cnt + N'(1);
               end else begin
                  if (ns_cnt != '1) begin
                     ns_cnt <= ns_cnt + M'(1);
                  end
                  if (gate_timer != GATE_LEN) begin
                     gate_timer <= gate_timer + TW'(1);
                  end
                  if (sig_edge) begin
                     nx_cnt <= nx_cnt + N'(1);
                  end
               end
            end
            default: begin
               ns_cnt     <= '0;
               nx_cnt     <= '0;
               gate_timer <= '0;
            end
         endcase
      end
   end

   // Remember how the measurement ended so DONE can publish either result or error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (ns_timeout) begin
         err_q <= 1'b1;
      end else if (gate_close) begin
         err_q <= 1'b0;
      end
   end

   // Publish operands in DONE; divisor is forced to 1 whenever there is no valid count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dividend <= '0;
         divisor  <= N'(1);
         ovf      <= 1'b0;
         op_valid <= 1'b0;
      end else begin
         op_valid <= (state == ST_DONE);
         if (state == ST_DONE) begin
            if (err_q) begin
               dividend <= '0;
               divisor  <= N'(1);
               ovf      <= 1'b1;
            end else begin
               dividend <= ns_cnt;
               divisor  <= nx_cnt;
               ovf      <= 1'b0;
            end
         end
      end
   end

   // Track divider latency; a fresh result restarts the countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_cnt   <= '0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= (q_cnt == QW'(1)) && (state != ST_DONE);
         if (state == ST_DONE) begin
            q_cnt <= LAT_LOAD;
         end else if (q_cnt != '0) begin
            q_cnt <= q_cnt - QW'(1);
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_period_gate_counter.sv
module tb_period_gate_counter;

   logic        clk;
   logic        rst_n;
   logic        start_a, cont_a, sig_a;
   logic        start_b, cont_b, sig_b;
   logic [25:0] dd_a;
   logic [13:0] dv_a;
   logic [11:0] dd_b;
   logic [5:0]  dv_b;
   logic        opv_a, qv_a, busy_a, ovf_a;
   logic        opv_b, qv_b, busy_b, ovf_b;

   int errors = 0;
   int checks = 0;

   int per_a = 10;
   int per_b = 10;
   bit run_a = 0;
   bit run_b = 0;

   // Instance A: M=26, N=14, gate 95 -> divider latency 12
   period_gate_counter #(.M(26), .N(14), .GATE_CYCLES(95)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .sig_in(sig_a),
      .dividend(dd_a), .divisor(dv_a), .op_valid(opv_a), .q_valid(qv_a),
      .busy(busy_a), .ovf(ovf_a)
   );

   // Instance B: M=12, N=6, gate 200 -> divider latency 6
   period_gate_counter #(.M(12), .N(6), .GATE_CYCLES(200)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .sig_in(sig_b),
      .dividend(dd_b), .divisor(dv_b), .op_valid(opv_b), .q_valid(qv_b),
      .busy(busy_b), .ovf(ovf_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Periodic signal generators (50% duty, high phase first)
   initial begin
      int ph = 0;
      sig_a = 1'b0;
      forever begin
         @(negedge clk);
         if (!run_a) begin
            sig_a = 1'b0;
            ph = 0;
         end else begin
            sig_a = (ph < per_a / 2) ? 1'b1 : 1'b0;
            ph = (ph + 1 >= per_a) ? 0 : ph + 1;
         end
      end
   end

   initial begin
      int ph = 0;
      sig_b = 1'b0;
      forever begin
         @(negedge clk);
         if (!run_b) begin
            sig_b = 1'b0;
            ph = 0;
         end else begin
            sig_b = (ph < per_b / 2) ? 1'b1 : 1'b0;
            ph = (ph + 1 >= per_b) ? 0 : ph + 1;
         end
      end
   end

   function automatic logic [31:0] rd_dd(input int i);
      return (i == 0) ? 32'(dd_a) : 32'(dd_b);
   endfunction
   function automatic logic [31:0] rd_dv(input int i);
      return (i == 0) ? 32'(dv_a) : 32'(dv_b);
   endfunction
   function automatic logic rd_opv(input int i);
      return (i == 0) ? opv_a : opv_b;
   endfunction
   function automatic logic rd_qv(input int i);
      return (i == 0) ? qv_a : qv_b;
   endfunction
   function automatic logic rd_busy(input int i);
      return (i == 0) ? busy_a : busy_b;
   endfunction
   function automatic logic rd_ovf(input int i);
      return (i == 0) ? ovf_a : ovf_b;
   endfunction
   function automatic int lat_of_inst(input int i);
      return (i == 0) ? (26 - 14) : (12 - 6);
   endfunction

   // Reference: K whole periods, K = first count with K*P >= gate, limited to 2^N-1
   task automatic model(input int i, input int per, output int edd, output int edv, output bit eovf);
      int g, nb, mb, k, ns;
      g  = (i == 0) ? 95 : 200;
      nb = (i == 0) ? 14 : 6;
      mb = (i == 0) ? 26 : 12;
      k  = (g + per - 1) / per;
      if (k > (1 << nb) - 1) k = (1 << nb) - 1;
      ns = k * per;
      if (ns > (1 << mb) - 2) begin
         edd = 0; edv = 1; eovf = 1'b1;
      end else begin
         edd = ns; edv = k; eovf = 1'b0;
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_sig(input int i, input int per);
      if (i == 0) begin run_a = 0; per_a = per; end
      else        begin run_b = 0; per_b = per; end
      repeat (6) @(negedge clk);
      if (i == 0) run_a = 1; else run_b = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_start(input int i);
      if (i == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      if (i == 0) start_a = 1'b0; else start_b = 1'b0;
   endtask

   task automatic wait_op(input int i, input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (rd_opv(i)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_qv(input int i, output int j);
      j = 0;
      while (j < 64) begin
         @(negedge clk);
         j++;
         if (rd_qv(i)) break;
      end
   endtask

   // One single-shot measurement checked against expected operands
   task automatic measure(input int i, input int per, input int edd, input int edv,
                          input bit eovf, input string nm);
      int cyc, j;
      bit ok;
      logic [31:0] dd, dv;
      set_sig(i, per);
      pulse_start(i);
      wait_op(i, 20000, cyc, ok);
      check($sformatf("%s_op_valid_seen", nm), 32'(ok), 32'd1);
      if (!ok) return;
      check($sformatf("%s_dividend", nm), rd_dd(i), 32'(edd));
      check($sformatf("%s_divisor", nm), rd_dv(i), 32'(edv));
      check($sformatf("%s_ovf", nm), 32'(rd_ovf(i)), 32'(eovf));
      wait_qv(i, j);
      check($sformatf("%s_q_latency", nm), 32'(j), 32'(lat_of_inst(i)));
      dd = rd_dd(i);
      dv = rd_dv(i);
      if (dv != 0) check($sformatf("%s_quotient", nm), dd / dv, 32'(edd / edv));
      else         check($sformatf("%s_divisor_nonzero", nm), dv, 32'd1);
      @(negedge clk);
      check($sformatf("%s_busy_after", nm), 32'(rd_busy(i)), 32'd0);
   endtask

   typedef struct {
      int inst;
      int per;
      int edd;
      int edv;
      bit eovf;
   } vec_t;

   // Watchdog: every wait is bounded, this only guards against a stuck simulator
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab[10];
      int cyc, j, extra, edd, edv, per, inst;
      bit ok, eovf, stable, busy_mid;

      tab[0] = '{0, 10, 100, 10, 1'b0};   // 10 periods of 10
      tab[1] = '{0,  7,  98, 14, 1'b0};   // first edge with timer>=95 is 14*7
      tab[2] = '{0,  3,  96, 32, 1'b0};
      tab[3] = '{0, 95,  95,  1, 1'b0};   // timer hits gate exactly on first period
      tab[4] = '{0, 50, 100,  2, 1'b0};
      tab[5] = '{0,  2,  96, 48, 1'b0};
      tab[6] = '{1,  2, 126, 63, 1'b0};   // Nx limit 2^6-1 closes the gate
      tab[7] = '{1,  3, 189, 63, 1'b0};
      tab[8] = '{1,  4, 200, 50, 1'b0};   // timer reaches 200 exactly
      tab[9] = '{1,  7, 203, 29, 1'b0};

      rst_n = 1'b0;
      start_a = 1'b0; cont_a = 1'b0;
      start_b = 1'b0; cont_b = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_dividend_a", 32'(dd_a), 32'd0);
      check("rst_divisor_a", 32'(dv_a), 32'd1);
      check("rst_op_valid_a", 32'(opv_a), 32'd0);
      check("rst_q_valid_a", 32'(qv_a), 32'd0);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_ovf_a", 32'(ovf_a), 32'd0);
      check("rst_divisor_b", 32'(dv_b), 32'd1);
      check("rst_busy_b", 32'(busy_b), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed table
      for (int k = 0; k < 10; k++) begin
         measure(tab[k].inst, tab[k].per, tab[k].edd, tab[k].edv, tab[k].eovf,
                 $sformatf("vec%0d", k));
      end

      // Timeout on B: 4095 ARM cycles, one DONE cycle, op_valid on the next
      run_b = 0;
      repeat (6) @(negedge clk);
      start_b = 1'b1;
      cyc = 0;
      ok = 1'b0;
      busy_mid = 1'b0;
      while (cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start_b = 1'b0;
         if (cyc == 100) busy_mid = busy_b;
         if (opv_b) begin ok = 1'b1; break; end
      end
      check("timeout_busy_mid", 32'(busy_mid), 32'd1);
      check("timeout_latency", 32'(cyc), 32'((1 << 12) - 1 + 2));
      check("timeout_ovf", 32'(ovf_b), 32'd1);
      check("timeout_dividend", 32'(dd_b), 32'd0);
      check("timeout_divisor", 32'(dv_b), 32'd1);
      @(negedge clk);
      check("timeout_busy_after", 32'(busy_b), 32'd0);

      // Randomized periods against the reference model (B rows also clear ovf)
      for (int k = 0; k < 10; k++) begin
         inst = k % 2;
         per  = (inst == 0) ? $urandom_range(2, 60) : $urandom_range(2, 30);
         model(inst, per, edd, edv, eovf);
         measure(inst, per, edd, edv, eovf, $sformatf("rnd%0d_p%0d", k, per));
      end

      // Continuous mode, then drop continuous: exactly one more result
      set_sig(0, 10);
      cont_a = 1'b1;
      pulse_start(0);
      for (int r = 0; r < 4; r++) begin
         cyc = 0; ok = 1'b0; stable = 1'b1;
         while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (opv_a) begin ok = 1'b1; break; end
            if (r > 0 && (dd_a != 26'd100 || dv_a != 14'd10)) stable = 1'b0;
         end
         check($sformatf("cont%0d_op_valid_seen", r), 32'(ok), 32'd1);
         if (r > 0) check($sformatf("cont%0d_stable", r), 32'(stable), 32'd1);
         check($sformatf("cont%0d_dividend", r), 32'(dd_a), 32'd100);
         check($sformatf("cont%0d_divisor", r), 32'(dv_a), 32'd10);
         if (r == 2) cont_a = 1'b0;
         wait_qv(0, j);
         check($sformatf("cont%0d_q_latency", r), 32'(j), 32'd12);
      end
      extra = 0;
      repeat (400) begin
         @(negedge clk);
         if (opv_a) extra++;
      end
      check("cont_extra_results", 32'(extra), 32'd0);
      check("cont_busy_end", 32'(busy_a), 32'd0);

      // Second start during GATE is ignored
      set_sig(0, 10);
      pulse_start(0);
      repeat (40) @(negedge clk);
      check("restart_busy_in_gate", 32'(busy_a), 32'd1);
      pulse_start(0);
      wait_op(0, 3000, cyc, ok);
      check("restart_op_valid_seen", 32'(ok), 32'd1);
      check("restart_dividend", 32'(dd_a), 32'd100);
      check("restart_divisor", 32'(dv_a), 32'd10);
      extra = 0;
      repeat (400) begin
         @(negedge clk);
         if (opv_a) extra++;
      end
      check("restart_extra_results", 32'(extra), 32'd0);

      // Asynchronous reset mid-GATE
      set_sig(0, 10);
      pulse_start(0);
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dividend", 32'(dd_a), 32'd0);
      check("arst_divisor", 32'(dv_a), 32'd1);
      check("arst_busy", 32'(busy_a), 32'd0);
      check("arst_op_valid", 32'(opv_a), 32'd0);
      check("arst_ovf", 32'(ovf_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (400) begin
         @(negedge clk);
         if (opv_a || qv_a) extra++;
      end
      check("arst_stray_pulses", 32'(extra), 32'd0);
      check("arst_busy_after", 32'(busy_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
